// File: rtl/add_serial_seq.sv
// add_serial_seq: operand FIFO feeding a serial adder, with a start/wait/capture/release sequencer and a held result.
module add_serial_seq #(
  parameter int LAT   = 8,
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  output logic       add_en,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  input  logic [7:0] add_out,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       busy,
  output logic [7:0] op_cnt
);
  localparam int AW = DEPTH > 2 ? 2 : 1;
  typedef enum logic [2:0] {IDLE, START, WAIT, CAPTURE, RELEASE} state_t;
  state_t state, state_nx;
  logic [15:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] occ;
  logic [7:0] cnt;
  logic push, fire;
  assign in_ready = occ != (AW+1)'(DEPTH);
  assign push = in_valid && in_ready;
  // a capture only happens when the result slot is free or being drained this cycle
  assign fire = state == CAPTURE && (!res_valid || res_ready);
  assign {add_a, add_b} = occ != '0 ? mem[rd_ptr] : 16'd0;
  assign add_en = state == START || state == RELEASE;
  assign busy = state != IDLE;
  always_comb begin
    state_nx = state == IDLE    ? (occ != '0 ? START : IDLE) :
               state == START   ? WAIT :
               state == WAIT    ? (cnt == 8'(LAT - 1) ? CAPTURE : WAIT) :
               state == CAPTURE ? (fire ? RELEASE : CAPTURE) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_a, in_b};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      op_cnt    <= '0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (fire) rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + (AW+1)'(push) - (AW+1)'(fire);
      cnt <= state == START ? 8'd0 : state == WAIT ? cnt + 8'd1 : cnt;
      if (fire) begin
        res_data  <= add_out;
        res_valid <= 1'b1;
        op_cnt    <= op_cnt + 8'd1;
      end else if (res_valid && res_ready) res_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_add_serial_seq.sv
// tb_add_serial_seq: random and directed stimulus checked every cycle against a timeline model of the sequencer.
module tb_add_serial_seq;
  localparam int LAT = 8;
  localparam int DEPTH = 2;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, add_en, res_valid, res_ready = 0, busy;
  logic [7:0] in_a = 0, in_b = 0, add_a, add_b, add_out = 0, res_data, op_cnt;
  int total = 0, bad = 0, cyc = 0;
  logic [15:0] q[$];
  bit job, captured, noisy;
  int age, tot, base, first_rv;
  int en_log[$];
  logic m_rv;
  logic [7:0] m_rd, m_cnt;

  add_serial_seq #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .add_en(add_en), .add_a(add_a), .add_b(add_b), .add_out(add_out), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .busy(busy), .op_cnt(op_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic chki(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    job = 0; captured = 0; age = 0; tot = 0;
    m_rv = 0; m_rd = 0; m_cnt = 0;
  endtask

  task automatic rst_task();
    @(negedge clk);
    rst = 1; in_valid = 0; res_ready = 0;
    #1;
    model_reset();
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_op_cnt", op_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_add_en", add_en, 0);
  endtask

  // One clock: drive inputs, compare outputs with the model, advance the model across the edge.
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b, input logic rr);
    bit cap, do_push;
    @(negedge clk);
    rst = 0; in_valid = v; in_a = a; in_b = b; res_ready = rr;
    add_out = (noisy || q.size() == 0) ? 8'($urandom) : q[0][15:8] + q[0][7:0];
    #1;
    chk("in_ready", in_ready, 8'(q.size() != DEPTH));
    chk("add_a", add_a, q.size() != 0 ? q[0][15:8] : 8'h00);
    chk("add_b", add_b, q.size() != 0 ? q[0][7:0] : 8'h00);
    chk("busy", busy, 8'(job));
    chk("add_en", add_en, 8'(job && (age == 0 || captured)));
    chk("res_valid", res_valid, 8'(m_rv));
    chk("res_data", res_data, m_rd);
    chk("op_cnt", op_cnt, m_cnt);
    if (add_en === 1'b1) en_log.push_back(cyc);
    if (res_valid === 1'b1 && first_rv < 0) first_rv = cyc;
    cap = 0;
    do_push = v && q.size() != DEPTH;
    if (!job) begin
      if (q.size() != 0) begin job = 1; age = 0; captured = 0; end
    end else if (captured) job = 0;
    else begin
      cap = age >= LAT + 1 && (!m_rv || rr);
      age++;
    end
    if (cap) begin
      m_rd = add_out; m_rv = 1; void'(q.pop_front()); m_cnt++; tot++; captured = 1;
    end else if (m_rv && rr) m_rv = 0;
    if (do_push) q.push_back({a, b});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    model_reset();
    noisy = 0;
    first_rv = -1;
    repeat (2) @(negedge clk);
    // single op: a=0x35 b=0x4A
    rst_task();
    step(1, 8'h35, 8'h4A, 1);
    base = cyc; en_log.delete(); first_rv = -1;
    repeat (14) step(0, 0, 0, 1);
    chki("single_en_cnt", en_log.size(), 2);
    if (en_log.size() >= 2) begin
      chki("single_start_cycle", en_log[0] - base, 1);
      chki("single_release_cycle", en_log[1] - base, 11);
    end
    chki("single_rv_cycle", first_rv - base, 11);
    chk("single_res", res_data, 8'h7F);
    chk("single_cnt", op_cnt, 8'h01);
    // overflow wraps to 8 bits
    step(1, 8'hFF, 8'h02, 1);
    repeat (14) step(0, 0, 0, 1);
    chk("ovf_res", res_data, 8'h01);
    chk("ovf_cnt", op_cnt, 8'h02);
    // backpressure: second op stalls in CAPTURE
    rst_task();
    step(1, 8'h35, 8'h4A, 0);
    step(1, 8'h10, 8'h20, 0);
    repeat (40) step(0, 0, 0, 0);
    chk("bp_held", res_data, 8'h7F);
    chk("bp_rv", res_valid, 1);
    chk("bp_stall_busy", busy, 1);
    chk("bp_cnt", op_cnt, 8'h01);
    step(0, 0, 0, 1);
    chk("bp_replace", res_data, 8'h30);
    chk("bp_rv2", res_valid, 1);
    chk("bp_cnt2", op_cnt, 8'h02);
    repeat (4) step(0, 0, 0, 1);
    // full FIFO: third push refused
    rst_task();
    step(1, 8'h01, 8'h01, 1);
    step(1, 8'h02, 8'h02, 1);
    chk("full_ready", in_ready, 0);
    step(1, 8'h03, 8'h03, 1);
    repeat (25) step(0, 0, 0, 1);
    chk("full_cnt", op_cnt, 8'h02);
    chk("full_res", res_data, 8'h04);
    // reset in WAIT
    rst_task();
    step(1, 8'h11, 8'h22, 1);
    repeat (6) step(0, 0, 0, 1);
    chk("wait_busy_pre", busy, 1);
    rst_task();
    step(0, 0, 0, 1);
    chk("post_rst_en", add_en, 0);
    chk("post_rst_busy", busy, 0);
    // random run long enough to wrap op_cnt and the FIFO pointers
    noisy = 1;
    rst_task();
    for (int i = 0; i < 5000; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), ($urandom % 4) != 0);
    chki("wrap_reached", int'(tot >= 256), 1);
    chk("wrap_cnt", op_cnt, 8'(tot));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
